// File: rtl/led_pkg.sv
// Shared definitions for the multi-channel LED driver: mode encodings and width helpers.
package led_pkg;

    localparam int unsigned MODE_W = 2;

    localparam logic [MODE_W-1:0] MODE_OFF     = 2'b00;
    localparam logic [MODE_W-1:0] MODE_ON      = 2'b01;
    localparam logic [MODE_W-1:0] MODE_BLINK   = 2'b10;
    localparam logic [MODE_W-1:0] MODE_ONESHOT = 2'b11;

    // Channel-select width; a single channel still needs a 1-bit select port.
    function automatic int unsigned ch_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/tick_gen.sv
// Free-running prescaler; o_tick is high for the one cycle in which the count is TICK_DIV-1.
module tick_gen #(
    parameter int unsigned TICK_DIV = 50_000
) (
    input  logic i_clk,
    input  logic i_rst_n,
    output logic o_tick
);

    localparam int unsigned CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

    logic [CNT_W-1:0] r_cnt;
    logic             r_tick;

    // Tick is registered one count early so it coincides with count == TICK_DIV-1.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_cnt  <= '0;
            r_tick <= 1'b0;
        end else begin
            if (r_cnt == CNT_W'(TICK_DIV - 1)) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            r_tick <= (r_cnt == CNT_W'(TICK_DIV - 2));
        end
    end

    assign o_tick = r_tick;

endmodule

// File: rtl/led_blink_multi.sv
// Multi-channel LED driver: shared tick prescaler, per-channel OFF/ON/BLINK/ONESHOT with
// a runtime half-period measured in ticks.
module led_blink_multi
    import led_pkg::*;
#(
    parameter int unsigned CH_NUM   = 4,
    parameter int unsigned TICK_DIV = 50_000,
    parameter int unsigned HP_W     = 10
) (
    input  logic                          sys_clk,
    input  logic                          sys_rst_n,
    input  logic                          cfg_we,
    input  logic [ch_width(CH_NUM)-1:0]   cfg_ch,
    input  logic [MODE_W-1:0]             cfg_mode,
    input  logic [HP_W-1:0]               cfg_half,
    output logic [CH_NUM-1:0]             led_out,
    output logic                          tick_out
);

    localparam int unsigned CH_W = ch_width(CH_NUM);

    logic w_tick;

    tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .i_clk   (sys_clk),
        .i_rst_n (sys_rst_n),
        .o_tick  (w_tick)
    );

    assign tick_out = w_tick;

    for (genvar i = 0; i < CH_NUM; i++) begin : g_ch
        logic [MODE_W-1:0] r_mode;
        logic [HP_W-1:0]   r_half;
        logic [HP_W-1:0]   r_count;
        logic              r_led;
        logic              w_wr;
        logic [HP_W-1:0]   w_last;

        // Selects beyond CH_NUM-1 match no channel, so such writes are dropped.
        assign w_wr   = cfg_we && (cfg_ch == CH_W'(i));
        assign w_last = (r_half == '0) ? '0 : (r_half - HP_W'(1));

        // A write on a tick cycle takes priority over the tick for this channel.
        always_ff @(posedge sys_clk) begin
            if (!sys_rst_n) begin
                r_mode  <= MODE_OFF;
                r_half  <= '0;
                r_count <= '0;
                r_led   <= 1'b0;
            end else if (w_wr) begin
                r_mode  <= cfg_mode;
                r_half  <= cfg_half;
                r_count <= '0;
                r_led   <= (cfg_mode != MODE_OFF);
            end else if (w_tick) begin
                case (r_mode)
                    MODE_BLINK: begin
                        if (r_count == w_last) begin
                            r_led   <= ~r_led;
                            r_count <= '0;
                        end else begin
                            r_count <= r_count + HP_W'(1);
                        end
                    end
                    MODE_ONESHOT: begin
                        if (r_count == w_last) begin
                            r_led   <= 1'b0;
                            r_mode  <= MODE_OFF;
                            r_count <= '0;
                        end else begin
                            r_count <= r_count + HP_W'(1);
                        end
                    end
                    default: begin
                        r_count <= '0;
                    end
                endcase
            end
        end

        assign led_out[i] = r_led;
    end

endmodule

// File: tb/tb_led_blink_multi.sv
// Scoreboard bench for led_blink_multi: stimulus queues per-cycle expectations,
// a negedge monitor compares them against led_out/tick_out.
module tb_led_blink_multi;

    logic       clk;
    logic       rst_n;
    logic       cfg_we;
    logic [1:0] cfg_ch;
    logic [1:0] cfg_mode;
    logic [3:0] cfg_half;
    logic [3:0] led_out;
    logic       tick_out;

    led_blink_multi #(
        .CH_NUM   (4),
        .TICK_DIV (4),
        .HP_W     (4)
    ) dut (
        .sys_clk   (clk),
        .sys_rst_n (rst_n),
        .cfg_we    (cfg_we),
        .cfg_ch    (cfg_ch),
        .cfg_mode  (cfg_mode),
        .cfg_half  (cfg_half),
        .led_out   (led_out),
        .tick_out  (tick_out)
    );

    typedef struct {
        int         cyc;
        bit         is_tick;
        logic [3:0] mask;
        logic [3:0] val;
        string      nm;
    } exp_t;

    exp_t sb_q[$];
    int   cyc     = 0;
    int   n_check = 0;
    int   n_fail  = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // cyc equals the number of rising edges seen so far.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic exp_led(input int c, input logic [3:0] m, input logic [3:0] v, input string nm);
        exp_t e;
        e.cyc = c; e.is_tick = 1'b0; e.mask = m; e.val = v; e.nm = nm;
        sb_q.push_back(e);
    endtask

    task automatic exp_tick(input int c, input logic v, input string nm);
        exp_t e;
        e.cyc = c; e.is_tick = 1'b1; e.mask = 4'b0001; e.val = {3'b000, v}; e.nm = nm;
        sb_q.push_back(e);
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drive one write during cycle c; it is sampled at the edge that starts cycle c+1.
    task automatic cfg_write(input int c, input logic [1:0] ch, input logic [1:0] md,
                             input logic [3:0] hf);
        wait_cyc(c);
        cfg_we = 1'b1; cfg_ch = ch; cfg_mode = md; cfg_half = hf;
        wait_cyc(c + 1);
        cfg_we = 1'b0;
    endtask

    // Monitor: compare every expectation that falls due in the current cycle.
    always @(negedge clk) begin
        logic [3:0] act;
        for (int i = sb_q.size() - 1; i >= 0; i--) begin
            if (sb_q[i].cyc == cyc) begin
                act = sb_q[i].is_tick ? {3'b000, tick_out} : (led_out & sb_q[i].mask);
                n_check++;
                if (act !== sb_q[i].val) begin
                    n_fail++;
                    $display("FAIL %s cyc=%0d got=%b want=%b", sb_q[i].nm, cyc, act, sb_q[i].val);
                end
                sb_q.delete(i);
            end else if (sb_q[i].cyc < cyc) begin
                n_check++;
                n_fail++;
                $display("FAIL %s cyc=%0d not checked in time (due %0d)", sb_q[i].nm, cyc, sb_q[i].cyc);
                sb_q.delete(i);
            end
        end
    end

    initial begin
        rst_n = 1'b0; cfg_we = 1'b0; cfg_ch = '0; cfg_mode = '0; cfg_half = '0;

        // Reset and prescaler: ticks at cycles 6, 10, 14, 18 after release during cycle 3.
        exp_led(1, 4'b1111, 4'b0000, "reset_led");
        exp_led(3, 4'b1111, 4'b0000, "reset_led_rel");
        for (int c = 1; c <= 19; c++) begin
            exp_tick(c, (c >= 6 && (c % 4) == 2), "tick_phase");
        end
        wait_cyc(3);
        rst_n = 1'b1;

        // ch1 ON then OFF.
        exp_led(20, 4'b1111, 4'b0000, "ch1_pre");
        exp_led(21, 4'b1111, 4'b0010, "ch1_on");
        exp_led(22, 4'b1111, 4'b0000, "ch1_off");
        cfg_write(20, 2'd1, 2'b01, 4'd0);
        cfg_write(21, 2'd1, 2'b00, 4'd0);

        // ch0 BLINK half=3: high at 24, toggles at 35 then every 12 cycles.
        exp_led(24, 4'b0001, 4'b0001, "ch0_start");
        for (int k = 0; k <= 8; k++) begin
            exp_led(34 + 12 * k, 4'b0001, (k % 2 == 0) ? 4'b0001 : 4'b0000, "ch0_pre_toggle");
            exp_led(35 + 12 * k, 4'b0001, (k % 2 == 0) ? 4'b0000 : 4'b0001, "ch0_toggle");
        end
        cfg_write(23, 2'd0, 2'b10, 4'd3);

        // ch2 ONESHOT half=2: high 40..46, low from 47 onward.
        exp_led(40, 4'b0100, 4'b0100, "ch2_start");
        exp_led(46, 4'b0100, 4'b0100, "ch2_hold");
        for (int c = 47; c <= 90; c++) begin
            exp_led(c, 4'b0100, 4'b0000, "ch2_done");
        end
        cfg_write(39, 2'd2, 2'b11, 4'd2);

        // ch3 BLINK half=0: toggles every tick (every 4 cycles).
        exp_led(52, 4'b1000, 4'b1000, "ch3_start");
        for (int j = 0; j <= 5; j++) begin
            exp_led(54 + 4 * j, 4'b1000, (j % 2 == 0) ? 4'b1000 : 4'b0000, "ch3_pre_toggle");
            exp_led(55 + 4 * j, 4'b1000, (j % 2 == 0) ? 4'b0000 : 4'b1000, "ch3_toggle");
        end
        cfg_write(51, 2'd3, 2'b10, 4'd0);

        // Rewrite ch3 (BLINK half=2) on the tick of cycle 78: restart high, tick ignored.
        exp_tick(78, 1'b1, "tick_at_rewrite");
        exp_led(78, 4'b1000, 4'b1000, "ch3_before_rewrite");
        exp_led(79, 4'b1000, 4'b1000, "ch3_write_wins");
        exp_led(86, 4'b1000, 4'b1000, "ch3_hp2_hold");
        exp_led(87, 4'b1000, 4'b0000, "ch3_hp2_toggle");
        exp_led(94, 4'b1000, 4'b0000, "ch3_hp2_low");
        exp_led(95, 4'b1000, 4'b1000, "ch3_hp2_high");
        cfg_write(78, 2'd3, 2'b10, 4'd2);

        // Reset mid-blink during cycle 132.
        exp_led(132, 4'b1111, 4'b1000, "pre_reset_leds");
        exp_led(133, 4'b1111, 4'b0000, "mid_reset_leds");
        exp_tick(133, 1'b0, "mid_reset_tick");
        exp_led(137, 4'b1111, 4'b0000, "post_reset_leds");
        wait_cyc(132);
        rst_n = 1'b0;
        wait_cyc(134);
        rst_n = 1'b1;

        wait_cyc(140);
        @(posedge clk);
        #1;
        if (sb_q.size() != 0) begin
            n_check++;
            n_fail++;
            $display("FAIL scoreboard_drain got=%0d pending want=0", sb_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_check, n_fail);
        $finish;
    end

endmodule
